// File: rtl/stb_queue.sv
// Store buffer queue: circular FIFO of pending stores, drained to the cache.
// Forwards the youngest matching entry to loads and supports a full flush.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   dmem_sel_i          data-memory select from dbus
//   lsu_req_i/lsu_we_i  store request / write enable from the LSU
//   lsu_addr_i          store address
//   lsu_wdata_i         store data
//   lsu_be_i            store byte enables
//   stb_ack_o           store accepted (one-cycle pulse, cycle after accept)
//   stb_stall_o         store present but cannot be accepted this cycle
//   cache_req_o         drain write request (head entry valid)
//   cache_addr_o        head entry address
//   cache_wdata_o       head entry data
//   cache_be_o          head entry byte enables
//   cache_ack_i         cache accepted the current drain write
//   fwd_addr_i          load lookup address
//   fwd_hit_o           a valid entry matches the lookup word
//   fwd_data_o          data of the youngest matching entry
//   fwd_be_o            byte enables of the youngest matching entry
//   flush_i             drain everything, blocking new stores meanwhile
//   flush_done_o        buffer empty after a flush (one-cycle pulse)
//   count_o             number of valid entries
module stb_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dmem_sel_i,
    input  logic                    lsu_req_i,
    input  logic                    lsu_we_i,
    input  logic [ADDR_W-1:0]       lsu_addr_i,
    input  logic [DATA_W-1:0]       lsu_wdata_i,
    input  logic [DATA_W/8-1:0]     lsu_be_i,
    output logic                    stb_ack_o,
    output logic                    stb_stall_o,
    output logic                    cache_req_o,
    output logic [ADDR_W-1:0]       cache_addr_o,
    output logic [DATA_W-1:0]       cache_wdata_o,
    output logic [DATA_W/8-1:0]     cache_be_o,
    input  logic                    cache_ack_i,
    input  logic [ADDR_W-1:0]       fwd_addr_i,
    output logic                    fwd_hit_o,
    output logic [DATA_W-1:0]       fwd_data_o,
    output logic [DATA_W/8-1:0]     fwd_be_o,
    input  logic                    flush_i,
    output logic                    flush_done_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BE_W  = DATA_W / 8;

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    // Drain FSM encoding
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // Entry storage; deliberately not reset, validity comes from count
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [BE_W-1:0]   mem_be   [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic             flush_pending;

    logic             store;
    logic             accept;
    logic             pop;
    logic             busy;
    logic             full;

    logic [PTR_W-1:0] fwd_idx;
    logic             unused_fwd_lsb;

    // Lookup is word-granular, so the byte offset bits are ignored
    assign unused_fwd_lsb = ^fwd_addr_i[1:0];

    // ------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------
    assign store  = dmem_sel_i & lsu_req_i & lsu_we_i;
    assign full   = (count == CNT_MAX);
    assign busy   = (state == BUSY);

    // Fullness uses the registered count, so a same-cycle drain ack
    // does not free a slot until the next cycle.
    assign accept = store & ~full & ~flush_pending;
    assign pop    = busy & cache_ack_i;

    assign stb_stall_o = store & (full | flush_pending);

    // Flush completes as soon as the buffer is observed empty
    assign flush_done_o = flush_pending & (count == '0);

    assign count_o = count;

    // ------------------------------------------------------------
    // Occupancy
    // ------------------------------------------------------------
    always_comb begin
        count_nxt = count;
        unique case ({accept, pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    // ------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // Stay busy for back-to-back drain while entries remain
                if (pop && (count_nxt == '0)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Head entry drives the cache port only while a write is in flight
    assign cache_req_o   = busy;
    assign cache_addr_o  = busy ? mem_addr[rd_ptr] : '0;
    assign cache_wdata_o = busy ? mem_data[rd_ptr] : '0;
    assign cache_be_o    = busy ? mem_be[rd_ptr]   : '0;

    // ------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            state         <= IDLE;
            flush_pending <= 1'b0;
            stb_ack_o     <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count     <= count_nxt;
            state     <= state_nxt;
            stb_ack_o <= accept;
            // A new flush request re-arms even as the old one completes
            flush_pending <= flush_i | (flush_pending & ~flush_done_o);
        end
    end

    // ------------------------------------------------------------
    // Entry write port
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_addr[wr_ptr] <= lsu_addr_i;
            mem_data[wr_ptr] <= lsu_wdata_i;
            mem_be[wr_ptr]   <= lsu_be_i;
        end
    end

    // ------------------------------------------------------------
    // Store-to-load forwarding
    // ------------------------------------------------------------
    // Walk from oldest (rd_ptr) to youngest; later matches overwrite
    // earlier ones so the youngest store wins. The entry being drained
    // is still valid and takes part in the search.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        fwd_be_o   = '0;
        fwd_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) &&
                (mem_addr[fwd_idx][ADDR_W-1:2] ==
                 fwd_addr_i[ADDR_W-1:2])) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = mem_data[fwd_idx];
                fwd_be_o   = mem_be[fwd_idx];
            end
        end
    end

endmodule

// File: tb/tb_stb_queue.sv
// Directed self-checking bench for stb_queue (DEPTH=4, 32-bit).
// Linear sequence of steps with hand-computed expectations.
module tb_stb_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmem_sel_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic [3:0]  lsu_be_i;
    logic        stb_ack_o;
    logic        stb_stall_o;
    logic        cache_req_o;
    logic [31:0] cache_addr_o;
    logic [31:0] cache_wdata_o;
    logic [3:0]  cache_be_o;
    logic        cache_ack_i;
    logic [31:0] fwd_addr_i;
    logic        fwd_hit_o;
    logic [31:0] fwd_data_o;
    logic [3:0]  fwd_be_o;
    logic        flush_i;
    logic        flush_done_o;
    logic [2:0]  count_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    stb_queue dut (
        .clk          (clk),
        .rst          (rst),
        .dmem_sel_i   (dmem_sel_i),
        .lsu_req_i    (lsu_req_i),
        .lsu_we_i     (lsu_we_i),
        .lsu_addr_i   (lsu_addr_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .lsu_be_i     (lsu_be_i),
        .stb_ack_o    (stb_ack_o),
        .stb_stall_o  (stb_stall_o),
        .cache_req_o  (cache_req_o),
        .cache_addr_o (cache_addr_o),
        .cache_wdata_o(cache_wdata_o),
        .cache_be_o   (cache_be_o),
        .cache_ack_i  (cache_ack_i),
        .fwd_addr_i   (fwd_addr_i),
        .fwd_hit_o    (fwd_hit_o),
        .fwd_data_o   (fwd_data_o),
        .fwd_be_o     (fwd_be_o),
        .flush_i      (flush_i),
        .flush_done_o (flush_done_o),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: run did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store_on(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] b);
        dmem_sel_i  = 1'b1;
        lsu_req_i   = 1'b1;
        lsu_we_i    = 1'b1;
        lsu_addr_i  = a;
        lsu_wdata_i = d;
        lsu_be_i    = b;
    endtask

    task automatic store_off();
        dmem_sel_i = 1'b0;
        lsu_req_i  = 1'b0;
        lsu_we_i   = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        store_off();
        lsu_addr_i  = '0;
        lsu_wdata_i = '0;
        lsu_be_i    = '0;
        cache_ack_i = 1'b0;
        fwd_addr_i  = '0;
        flush_i     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        // Reset state
        chk("rst_count", count_o, 0);
        chk("rst_req", cache_req_o, 0);
        chk("rst_ack", stb_ack_o, 0);
        chk("rst_fdone", flush_done_o, 0);
        chk("rst_stall", stb_stall_o, 0);
        chk("rst_hit", fwd_hit_o, 0);

        // Single store then drain
        store_on(32'h100, 32'hAABBCCDD, 4'hF);
        #1;
        chk("s1_stall", stb_stall_o, 0);
        tick();
        store_off();
        chk("s1_ack", stb_ack_o, 1);
        chk("s1_count", count_o, 1);
        chk("s1_req_idle", cache_req_o, 0);
        tick();
        chk("s1_ack_pulse", stb_ack_o, 0);
        chk("s1_req", cache_req_o, 1);
        chk("s1_addr", cache_addr_o, 32'h100);
        chk("s1_data", cache_wdata_o, 32'hAABBCCDD);
        chk("s1_be", cache_be_o, 4'hF);
        cache_ack_i = 1'b1;
        tick();
        cache_ack_i = 1'b0;
        chk("s1_count0", count_o, 0);
        chk("s1_req0", cache_req_o, 0);

        // Fill to full, stall, release by one ack
        for (int i = 0; i < 4; i++) begin
            store_on(32'h10 + 32'(4 * i), 32'(i + 1), 4'hF);
            tick();
        end
        store_on(32'h20, 32'd5, 4'hF);
        #1;
        chk("full_count", count_o, 4);
        chk("full_stall", stb_stall_o, 1);
        tick();
        chk("full_hold", count_o, 4);
        chk("full_noack", stb_ack_o, 0);
        chk("full_head", cache_addr_o, 32'h10);
        cache_ack_i = 1'b1;
        #1;
        chk("full_ack_stall", stb_stall_o, 1);
        tick();
        cache_ack_i = 1'b0;
        #1;
        chk("full_unstall", stb_stall_o, 0);
        chk("full_cnt3", count_o, 3);
        chk("full_next", cache_addr_o, 32'h14);
        tick();
        store_off();
        chk("fifth_ack", stb_ack_o, 1);
        chk("fifth_cnt", count_o, 4);
        cache_ack_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_data", cache_wdata_o, 32'(k + 2));
            tick();
        end
        cache_ack_i = 1'b0;
        chk("drain_cnt0", count_o, 0);
        chk("drain_req0", cache_req_o, 0);

        // Forwarding, youngest wins
        store_on(32'h200, 32'h1, 4'hF);
        tick();
        store_on(32'h200, 32'h2, 4'h3);
        tick();
        store_off();
        fwd_addr_i = 32'h200;
        #1;
        chk("fwd_hit", fwd_hit_o, 1);
        chk("fwd_data", fwd_data_o, 32'h2);
        chk("fwd_be", fwd_be_o, 4'h3);
        fwd_addr_i = 32'h202;
        #1;
        chk("fwd_word_hit", fwd_hit_o, 1);
        fwd_addr_i = 32'h204;
        #1;
        chk("fwd_miss", fwd_hit_o, 0);
        chk("fwd_miss_data", fwd_data_o, 0);
        chk("fwd_miss_be", fwd_be_o, 0);
        fwd_addr_i = 32'h200;
        cache_ack_i = 1'b1;
        tick();
        chk("fwd_drain_cnt", count_o, 1);
        chk("fwd_drain_data", fwd_data_o, 32'h2);
        tick();
        cache_ack_i = 1'b0;
        chk("fwd_empty_hit", fwd_hit_o, 0);

        // Flush with three entries, ack held high
        for (int i = 0; i < 3; i++) begin
            store_on(32'h300 + 32'(4 * i), 32'h30 + 32'(i), 4'hF);
            tick();
        end
        store_off();
        chk("fl_cnt3", count_o, 3);
        chk("fl_head", cache_wdata_o, 32'h30);
        flush_i = 1'b1;
        cache_ack_i = 1'b1;
        tick();
        flush_i = 1'b0;
        store_on(32'h400, 32'h40, 4'hF);
        #1;
        chk("fl_stall1", stb_stall_o, 1);
        chk("fl_data1", cache_wdata_o, 32'h31);
        chk("fl_done1", flush_done_o, 0);
        tick();
        chk("fl_stall2", stb_stall_o, 1);
        chk("fl_data2", cache_wdata_o, 32'h32);
        chk("fl_req2", cache_req_o, 1);
        tick();
        chk("fl_stall3", stb_stall_o, 1);
        chk("fl_done", flush_done_o, 1);
        chk("fl_cnt0", count_o, 0);
        chk("fl_req0", cache_req_o, 0);
        store_off();
        cache_ack_i = 1'b0;
        tick();
        chk("fl_done_pulse", flush_done_o, 0);
        chk("fl_noaccept", stb_ack_o, 0);
        chk("fl_cnt_end", count_o, 0);

        // Flush while empty
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fe_done", flush_done_o, 1);
        tick();
        chk("fe_done_pulse", flush_done_o, 0);

        // Steady accept + pop at count=2, pointers wrap
        store_on(32'h500, 32'h50, 4'hF);
        exp_q.push_back(32'h50);
        tick();
        store_on(32'h504, 32'h51, 4'hF);
        exp_q.push_back(32'h51);
        tick();
        for (int i = 0; i < 10; i++) begin
            store_on(32'h600 + 32'(4 * i), 32'h60 + 32'(i), 4'hF);
            cache_ack_i = 1'b1;
            #1;
            chk("wrap_head", cache_wdata_o, exp_q[0]);
            void'(exp_q.pop_front());
            exp_q.push_back(32'h60 + 32'(i));
            tick();
            chk("wrap_cnt", count_o, 2);
            chk("wrap_ack", stb_ack_o, 1);
        end
        store_off();
        for (int k = 0; k < 2; k++) begin
            chk("wrap_tail", cache_wdata_o, exp_q[0]);
            void'(exp_q.pop_front());
            tick();
        end
        cache_ack_i = 1'b0;
        chk("wrap_cnt0", count_o, 0);

        // Reset while busy with three entries
        for (int i = 0; i < 3; i++) begin
            store_on(32'h700 + 32'(4 * i), 32'h70 + 32'(i), 4'hF);
            tick();
        end
        store_off();
        chk("rb_cnt3", count_o, 3);
        chk("rb_req", cache_req_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rb_cnt0", count_o, 0);
        chk("rb_req0", cache_req_o, 0);
        chk("rb_ack0", stb_ack_o, 0);
        store_on(32'h800, 32'h88, 4'h5);
        tick();
        store_off();
        tick();
        chk("rb_fresh_addr", cache_addr_o, 32'h800);
        chk("rb_fresh_be", cache_be_o, 4'h5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stb_queue.md
STB_QUEUE -- requirements
Module: stb_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffer entries; power of two, at least 2.
REQ-002 Parameter ADDR_W, default 32, store address width.
REQ-003 Parameter DATA_W, default 32, store data width; multiple of 8.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 dmem_sel_i  in  1  data-memory select from dbus.
REQ-007 lsu_req_i / lsu_we_i  in  1 / 1  store request and write enable from the LSU over dbus.
REQ-008 lsu_addr_i / lsu_wdata_i / lsu_be_i  in  ADDR_W / DATA_W / DATA_W/8  store address, data and byte enables.
REQ-009 stb_ack_o  out  1  store accepted, one-cycle pulse.
REQ-010 stb_stall_o  out  1  store cannot be accepted this cycle.
REQ-011 cache_req_o  out  1  drain write request to cache.
REQ-012 cache_addr_o / cache_wdata_o / cache_be_o  out  ADDR_W / DATA_W / DATA_W/8  head entry contents.
REQ-013 cache_ack_i  in  1  cache accepted the current drain write.
REQ-014 fwd_addr_i  in  ADDR_W  load lookup address.
REQ-015 fwd_hit_o / fwd_data_o / fwd_be_o  out  1 / DATA_W / DATA_W/8  forwarding result.
REQ-016 flush_i  in  1  request to drain the buffer completely.
REQ-017 flush_done_o  out  1  flush complete, one-cycle pulse.
REQ-018 count_o  out  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-019 Storage is a circular FIFO with wr_ptr, rd_ptr and count; both pointers wrap from DEPTH-1 to 0.
REQ-020 A store is defined as dmem_sel_i & lsu_req_i & lsu_we_i.
REQ-021 A store is accepted when count<DEPTH and no flush is pending; count is the registered value.
REQ-022 On acceptance: the entry is written at wr_ptr, wr_ptr increments, and stb_ack_o goes high the next cycle for exactly one cycle.
REQ-023 stb_stall_o is combinational: it equals a store present AND (count==DEPTH OR flush pending).
REQ-024 While full, a cache_ack_i in the same cycle does not lift the stall; the store is accepted the following cycle.
REQ-025 The drain FSM has two states, IDLE and BUSY.
REQ-026 IDLE -> BUSY when count>0.
REQ-027 In BUSY: cache_req_o=1, and the cache_* outputs come from entry rd_ptr; they are held stable until cache_ack_i.
REQ-028 In BUSY on cache_ack_i: rd_ptr increments; the FSM goes to IDLE if the post-update count is 0, otherwise it stays BUSY with the next entry presented the next cycle (back-to-back drain).
REQ-029 cache_ack_i is ignored in IDLE.
REQ-030 An accept and a pop in the same cycle leave count unchanged.
REQ-031 flush_i sets flush_pending, which blocks new accepts.
REQ-032 When flush_pending and count==0: flush_done_o pulses for one cycle, and flush_pending clears in that same cycle.
REQ-033 flush_i while already empty: flush_done_o pulses the next cycle.
REQ-034 Forwarding is combinational over all valid entries, including the entry currently being drained.
REQ-035 A forwarding match is addr[ADDR_W-1:2] equality; the youngest match wins.
REQ-036 On a match: fwd_hit_o=1 and fwd_data_o/fwd_be_o come from that entry; otherwise all forwarding outputs are 0.
REQ-037 count_o reflects the registered count.

Reset
REQ-038 While rst=1 at a clock edge, the next state is: pointers 0, count 0, FSM IDLE, flush_pending 0.
REQ-039 After reset, all registered outputs are 0; entry storage is not cleared.
REQ-040 Reset during BUSY abandons the in-flight write: cache_req_o=0 the cycle after the reset edge.

Verification
REQ-041 DEPTH=4. One store at addr 0x100, data 0xAABBCCDD, be 0xF -> stb_ack_o the next cycle; cache_req_o with the same values; ack -> count_o returns to 0.
REQ-042 Four stores with no cache_ack_i -> count_o=4; a fifth store sees stb_stall_o=1; a single ack -> the fifth store is accepted the cycle after.
REQ-043 Stores to 0x200 (data 0x1) then 0x200 (data 0x2); fwd_addr_i=0x200 -> fwd_hit_o=1, fwd_data_o=0x2; fwd_addr_i=0x204 -> fwd_hit_o=0.
REQ-044 Three entries plus flush_i, with ack held high -> three back-to-back writes, then a flush_done_o pulse; stores stall throughout.
REQ-045 Simultaneous accept and ack with count=2 -> count_o stays 2, and pointers wrap correctly over 10 iterations.
REQ-046 rst=1 while BUSY with count=3 -> count_o=0 and cache_req_o=0 the next cycle.
